// File: rtl/if_stage.sv
// if_stage: PC, request/ack instruction-memory port and IF/ID pipeline register.
// Build option: define IF_FLUSH_ON_REDIRECT_EN to squash on redirect (default: one delay slot).
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out
);
  typedef enum logic [1:0] {IDLE, REQ, HELD, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_buf;
  logic [31:0] target;
  logic        pending;
  logic [31:0] pc_inc;
  logic [31:0] redir_pc;
  logic [31:0] next_target;

  assign pc_inc      = pc + 32'd4;
  assign redir_pc    = redirect_pc & ~32'd3;
  assign next_target = redirect_valid ? redir_pc : target;
  assign imem_addr   = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pc              <= RESET_PC & ~32'd3;
      hold_buf        <= '0;
      target          <= '0;
      pending         <= 1'b0;
      imem_req        <= 1'b0;
      instruction_out <= NOP_INSTR;
      pc_plus4_out    <= '0;
      valid_out       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          if (redirect_valid) pc <= redir_pc;
        end

        REQ: begin
`ifdef IF_FLUSH_ON_REDIRECT_EN
          if (redirect_valid) begin
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
            if (imem_ack) begin
              pc <= redir_pc;
            end else begin
              target  <= redir_pc;
              pending <= 1'b1;
              state   <= DRAIN;
            end
          end else
`endif
          if (imem_ack) begin
            if (stall_in) begin
              hold_buf <= imem_rdata;
              imem_req <= 1'b0;
              state    <= HELD;
              if (redirect_valid) begin
                target  <= redir_pc;
                pending <= 1'b1;
              end
            end else begin
              instruction_out <= imem_rdata;
              pc_plus4_out    <= pc_inc;
              valid_out       <= 1'b1;
              pc              <= redirect_valid ? redir_pc : pc_inc;
            end
          end else begin
            if (redirect_valid) begin
              target  <= redir_pc;
              pending <= 1'b1;
              state   <= DRAIN;
            end
            if (!stall_in) begin
              instruction_out <= NOP_INSTR;
              valid_out       <= 1'b0;
            end
          end
        end

        DRAIN: begin
          if (redirect_valid) target <= redir_pc;
`ifdef IF_FLUSH_ON_REDIRECT_EN
          if (redirect_valid || !stall_in) begin
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
          end
          if (imem_ack) begin
            pc      <= next_target;
            pending <= 1'b0;
            state   <= REQ;
          end
`else
          // A stalled delay-slot word parks in HELD with pending kept, so its PC+4 stays correct.
          if (imem_ack && stall_in) begin
            hold_buf <= imem_rdata;
            imem_req <= 1'b0;
            state    <= HELD;
          end else if (imem_ack) begin
            instruction_out <= imem_rdata;
            pc_plus4_out    <= pc_inc;
            valid_out       <= 1'b1;
            pc              <= next_target;
            pending         <= 1'b0;
            state           <= REQ;
          end else if (!stall_in) begin
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
          end
`endif
        end

        HELD: begin
`ifdef IF_FLUSH_ON_REDIRECT_EN
          if (redirect_valid) begin
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
            pc              <= redir_pc;
            pending         <= 1'b0;
            imem_req        <= 1'b1;
            state           <= REQ;
          end else
`else
          if (redirect_valid) begin
            target  <= redir_pc;
            pending <= 1'b1;
          end
`endif
          if (!stall_in) begin
            instruction_out <= hold_buf;
            pc_plus4_out    <= pc_inc;
            valid_out       <= 1'b1;
            pc              <= (pending || redirect_valid) ? next_target : pc_inc;
            pending         <= 1'b0;
            imem_req        <= 1'b1;
            state           <= REQ;
          end
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written corner sequences, and
// randomized traffic against an in-order fetch-stream model.
module tb_if_stage;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] instruction_out;
  logic [31:0] pc_plus4_out;
  logic        valid_out;

  int checks = 0;
  int failures = 0;

  if_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .instruction_out(instruction_out),
    .pc_plus4_out(pc_plus4_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA500_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  function automatic vec_t v(input logic s, input logic r, input logic [31:0] rp, input logic a,
                             input logic q, input logic [31:0] ad, input logic vl,
                             input logic [31:0] in, input logic [31:0] p4);
    vec_t t;
    t.stall = s; t.redir = r; t.rpc = rp; t.ack = a;
    t.req = q; t.addr = ad; t.valid = vl; t.instr = in; t.pc4 = p4;
    return t;
  endfunction

  vec_t        tbl[17];
  ent_t        expq[$];
  ent_t        e;
  logic [31:0] cur, tgt;
  int          consumed;
  logic        p_req, p_ack, p_stall, p_redir, p_valid;
  logic [31:0] p_addr, p_instr, p_pc4;
`ifdef IF_FLUSH_ON_REDIRECT_EN
  logic [31:0] daddr;
  logic        disc;
`else
  logic [31:0] ovr;
  logic        ovr_v;
`endif

  initial begin
    // Row = one cycle: outputs expected during the cycle, then inputs applied for its edge.
    tbl[0]  = v(0, 0, 0, 1,  0, RPC,          0, NOP,            0);
    tbl[1]  = v(0, 0, 0, 1,  1, 32'h100,      0, NOP,            0);
    tbl[2]  = v(0, 0, 0, 1,  1, 32'h104,      1, mem(32'h100),   32'h104);
    tbl[3]  = v(0, 0, 0, 1,  1, 32'h108,      1, mem(32'h104),   32'h108);
    tbl[4]  = v(0, 0, 0, 0,  1, 32'h10C,      1, mem(32'h108),   32'h10C);
    tbl[5]  = v(0, 0, 0, 0,  1, 32'h10C,      0, NOP,            32'h10C);
    tbl[6]  = v(0, 0, 0, 0,  1, 32'h10C,      0, NOP,            32'h10C);
    tbl[7]  = v(0, 0, 0, 1,  1, 32'h10C,      0, NOP,            32'h10C);
    tbl[8]  = v(1, 0, 0, 1,  1, 32'h110,      1, mem(32'h10C),   32'h110);
    tbl[9]  = v(1, 0, 0, 0,  0, 32'h110,      1, mem(32'h10C),   32'h110);
    tbl[10] = v(0, 0, 0, 0,  0, 32'h110,      1, mem(32'h10C),   32'h110);
    tbl[11] = v(0, 1, 32'h200, 1, 1, 32'h114, 1, mem(32'h110),   32'h114);
`ifdef IF_FLUSH_ON_REDIRECT_EN
    tbl[12] = v(0, 1, 32'h300, 0, 1, 32'h200, 0, NOP,            32'h114);
    tbl[13] = v(0, 0, 0, 0,  1, 32'h200,      0, NOP,            32'h114);
    tbl[14] = v(0, 0, 0, 1,  1, 32'h200,      0, NOP,            32'h114);
    tbl[15] = v(0, 0, 0, 1,  1, 32'h300,      0, NOP,            32'h114);
`else
    tbl[12] = v(0, 1, 32'h300, 0, 1, 32'h200, 1, mem(32'h114),   32'h118);
    tbl[13] = v(0, 0, 0, 0,  1, 32'h200,      0, NOP,            32'h118);
    tbl[14] = v(0, 0, 0, 1,  1, 32'h200,      0, NOP,            32'h118);
    tbl[15] = v(0, 0, 0, 1,  1, 32'h300,      1, mem(32'h200),   32'h204);
`endif
    tbl[16] = v(0, 0, 0, 0,  1, 32'h304,      1, mem(32'h300),   32'h304);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("r%0d_req", i),   imem_req,        tbl[i].req);
      chk($sformatf("r%0d_addr", i),  imem_addr,       tbl[i].addr);
      chk($sformatf("r%0d_valid", i), valid_out,       tbl[i].valid);
      chk($sformatf("r%0d_instr", i), instruction_out, tbl[i].instr);
      chk($sformatf("r%0d_pc4", i),   pc_plus4_out,    tbl[i].pc4);
      stall_in       = tbl[i].stall;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      imem_ack       = tbl[i].ack;
      imem_rdata     = tbl[i].ack ? mem(imem_addr) : 32'hDEAD_BEEF;
      @(negedge clk);
    end

    // PC wrap: low redirect bits are dropped, 0xFFFF_FFFC + 4 wraps to 0.
    stall_in = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    imem_ack = 1'b1; imem_rdata = mem(imem_addr);
    @(negedge clk);
    chk("wrap_addr_fffc", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = mem(imem_addr);
    @(negedge clk);
    chk("wrap_addr_0", imem_addr, 32'h0);
    chk("wrap_pc4", pc_plus4_out, 32'h0);
    chk("wrap_instr", instruction_out, mem(32'hFFFF_FFFC));
    chk("wrap_valid", valid_out, 1'b1);

    // Asynchronous reset during an outstanding request, then a stale ack in IDLE.
    imem_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_instr", instruction_out, NOP);
    chk("rst_pc4", pc_plus4_out, 32'h0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678; reset = 1'b0;
    chk("rel_idle_req", imem_req, 1'b0);
    @(negedge clk);
    chk("rel_req", imem_req, 1'b1);
    chk("rel_addr", imem_addr, RPC);
    chk("rel_valid", valid_out, 1'b0);
    imem_rdata = mem(imem_addr);
    @(negedge clk);
    chk("restart_addr", imem_addr, RPC + 32'd4);
    chk("restart_instr", instruction_out, mem(RPC));
    chk("restart_valid", valid_out, 1'b1);

    // Randomized traffic: every consumed instruction must follow the architectural fetch order.
    imem_ack = 1'b0; redirect_valid = 1'b0; stall_in = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cur = RPC; consumed = 0; expq.delete();
`ifdef IF_FLUSH_ON_REDIRECT_EN
    disc = 1'b0; daddr = '0;
`else
    ovr_v = 1'b0; ovr = '0;
`endif
    p_req = 0; p_ack = 0; p_stall = 0; p_redir = 0; p_valid = 0;
    p_addr = '0; p_instr = '0; p_pc4 = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) begin
        if (p_req && !p_ack && imem_req) chk("addr_stable", imem_addr, p_addr);
`ifdef IF_FLUSH_ON_REDIRECT_EN
        if (p_stall && !p_redir) begin
`else
        if (p_stall) begin
`endif
          chk("stall_hold_instr", instruction_out, p_instr);
          chk("stall_hold_pc4", pc_plus4_out, p_pc4);
          chk("stall_hold_valid", valid_out, p_valid);
        end
      end

      stall_in       = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc    = $urandom_range(0, 32'h3FFF);
      imem_ack       = imem_req && ($urandom_range(0, 99) < 60);
      imem_rdata     = imem_ack ? mem(imem_addr) : $urandom;
      tgt            = {redirect_pc[31:2], 2'b00};

      if (valid_out && !stall_in) begin
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_valid actual=%h required=no_instruction", instruction_out);
        end else begin
          e = expq.pop_front();
          chk("consume_instr", instruction_out, e.instr);
          chk("consume_pc4", pc_plus4_out, e.pc4);
          consumed++;
        end
      end

`ifdef IF_FLUSH_ON_REDIRECT_EN
      if (redirect_valid) begin
        expq.delete();
        if (imem_req && imem_ack) begin
          chk("ack_addr", imem_addr, disc ? daddr : cur);
          disc = 1'b0;
        end else if (imem_req && !disc) begin
          disc = 1'b1; daddr = cur;
        end
        cur = tgt;
      end else if (imem_req && imem_ack) begin
        if (disc) begin
          chk("drain_addr", imem_addr, daddr);
          disc = 1'b0;
        end else begin
          chk("ack_addr", imem_addr, cur);
          expq.push_back('{mem(cur), cur + 32'd4});
          cur = cur + 32'd4;
        end
      end
`else
      if (imem_req && imem_ack) begin
        chk("ack_addr", imem_addr, cur);
        expq.push_back('{mem(cur), cur + 32'd4});
        cur = redirect_valid ? tgt : (ovr_v ? ovr : cur + 32'd4);
        ovr_v = 1'b0;
      end else if (redirect_valid) begin
        if (imem_req) begin
          ovr = tgt; ovr_v = 1'b1;
        end else begin
          cur = tgt;
        end
      end
`endif

      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      p_stall = stall_in; p_redir = redirect_valid;
      p_instr = instruction_out; p_pc4 = pc_plus4_out; p_valid = valid_out;
      @(negedge clk);
    end
    chk("consumed_min", consumed >= 200, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
